// File: rtl/fifo_port_arb.sv
// Round-robin arbiter sharing one FIFO data port among NUM_REQ requesters, one burst per grant.
// Define FIFO_ARB_PRIO_EN to give requester 0 strict, burst-unlimited priority.
module fifo_port_arb #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_write,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy,
  output logic                     sel,
  output logic                     is_write,
  output logic                     w_enable,
  output logic [WIDTH-1:0]         w_data,
  input  logic                     w_ready,
  input  logic                     r_enable,
  output logic                     r_ready,
  input  logic [WIDTH-1:0]         r_data
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t          state, state_nx;
  logic [IDW-1:0]  ptr, ptr_nx, grant_nx, winner;
  logic            dir, dir_nx, found;
  logic [BW-1:0]   burst_cnt, burst_nx;
  logic            cur_valid, cur_write, fire, last_fire, unlimited, leave;
  int              idx;

  // First active requester at or above ptr, wrapping around the ring.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
`ifdef FIFO_ARB_PRIO_EN
    if (req_valid[0]) begin
      found = 1'b1;
    end else begin
      for (int k = 0; k < ((NUM_REQ > 1) ? NUM_REQ - 1 : 1); k++) begin
        idx = 1 + (((ptr == '0) ? 0 : int'(ptr) - 1) + k) % ((NUM_REQ > 1) ? NUM_REQ - 1 : 1);
        if (!found && idx < NUM_REQ && req_valid[idx]) begin
          found  = 1'b1;
          winner = IDW'(idx);
        end
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
`endif
  end

  assign cur_valid = req_valid[grant_id];
  assign cur_write = req_write[grant_id];
  assign fire      = (state == SERVE) && cur_valid && (cur_write == dir) && (dir ? w_ready : r_enable);
`ifdef FIFO_ARB_PRIO_EN
  assign unlimited = (grant_id == '0);
`else
  assign unlimited = 1'b0;
`endif
  assign last_fire = fire && !unlimited && (burst_cnt == BW'(MAX_BURST - 1));
  assign leave     = last_fire || !cur_valid || (cur_write != dir);

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    grant_nx = grant_id;
    dir_nx   = dir;
    burst_nx = burst_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nx = winner;
          dir_nx   = req_write[winner];
          burst_nx = '0;
          state_nx = SERVE;
        end
      end
      SERVE: begin
        if (fire && !unlimited) burst_nx = burst_cnt + BW'(1);
        if (leave) begin
          state_nx = IDLE;
`ifdef FIFO_ARB_PRIO_EN
          if (grant_id != '0)
            ptr_nx = (int'(grant_id) == NUM_REQ - 1) ? IDW'(1) : grant_id + IDW'(1);
`else
          ptr_nx = IDW'((int'(grant_id) + 1) % NUM_REQ);
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sel      = (state == SERVE);
    busy     = sel;
    is_write = sel && dir;
    w_data   = sel ? req_wdata[int'(grant_id)*WIDTH +: WIDTH] : '0;
    w_enable = fire && dir;
    r_ready  = fire && !dir;
    req_ack  = '0;
    if (fire) req_ack[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_id  <= '0;
      dir       <= 1'b0;
      burst_cnt <= '0;
      rsp_data  <= '0;
      rsp_valid <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      grant_id  <= grant_nx;
      dir       <= dir_nx;
      burst_cnt <= burst_nx;
      rsp_valid <= '0;
      // Read data is captured at the pop so the FIFO may advance immediately.
      if (fire && !dir) begin
        rsp_data            <= r_data;
        rsp_valid[grant_id] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_port_arb.sv
// Scoreboard bench for fifo_port_arb with a behavioural FIFO and per-requester op queues.
module tb_fifo_port_arb;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid, req_write, req_ack, rsp_valid;
  logic [NUM_REQ*WIDTH-1:0] req_wdata;
  logic [WIDTH-1:0]         rsp_data, w_data, r_data;
  logic [1:0]               grant_id;
  logic                     busy, sel, is_write, w_enable, w_ready, r_enable, r_ready;

  fifo_port_arb #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .grant_id(grant_id),
    .busy(busy), .sel(sel), .is_write(is_write), .w_enable(w_enable), .w_data(w_data),
    .w_ready(w_ready), .r_enable(r_enable), .r_ready(r_ready), .r_data(r_data)
  );

  int checks = 0;
  int failures = 0;

  logic       op_wr   [NUM_REQ][32];
  logic [7:0] op_data [NUM_REQ][32];
  int         head [NUM_REQ];
  int         tail [NUM_REQ];
  logic [7:0] fifo_q[$];
  logic       full_force;
  logic [9:0] exp_w[$];
  logic [9:0] exp_r[$];

  logic       s_sel, s_busy, s_is_write, s_wen, s_rready;
  logic [1:0] s_grant;
  logic [3:0] s_ack, s_rsp;
  logic [7:0] s_wdata, dummy;
  logic [9:0] e;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic driveInputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = head[i] < tail[i];
      req_write[i] = req_valid[i] ? op_wr[i][head[i]] : 1'b0;
      req_wdata[i*WIDTH +: WIDTH] = req_valid[i] ? op_data[i][head[i]] : 8'h00;
    end
    w_ready  = !full_force && (fifo_q.size() < DEPTH);
    r_enable = fifo_q.size() > 0;
    r_data   = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic addOp(input int i, input logic wr, input logic [7:0] d);
    op_wr[i][tail[i]]   = wr;
    op_data[i][tail[i]] = d;
    tail[i]++;
  endtask

  // One clock: sample and score at negedge, then let requesters and FIFO react after the edge.
  task automatic applyStimulus();
    @(negedge clk);
    s_sel = sel; s_busy = busy; s_is_write = is_write; s_wen = w_enable; s_rready = r_ready;
    s_grant = grant_id; s_ack = req_ack; s_rsp = rsp_valid; s_wdata = w_data;
    if (w_enable) begin
      checkOutput("w_sb_pending", {31'b0, exp_w.size() != 0}, 1);
      if (exp_w.size() > 0) begin
        e = exp_w.pop_front();
        checkOutput("w_id", {30'b0, grant_id}, {30'b0, e[9:8]});
        checkOutput("w_data", {24'b0, w_data}, {24'b0, e[7:0]});
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rsp_valid[i]) begin
        checkOutput("rsp_sb_pending", {31'b0, exp_r.size() != 0}, 1);
        if (exp_r.size() > 0) begin
          e = exp_r.pop_front();
          checkOutput("rsp_id", i, {30'b0, e[9:8]});
          checkOutput("rsp_data", {24'b0, rsp_data}, {24'b0, e[7:0]});
        end
      end
    end
    @(posedge clk);
    #1;
    if (s_wen) fifo_q.push_back(s_wdata);
    if (s_rready && fifo_q.size() > 0) dummy = fifo_q.pop_front();
    for (int i = 0; i < NUM_REQ; i++)
      if (s_ack[i] && head[i] < tail[i]) head[i]++;
    driveInputs();
  endtask

  logic [9:0] t1_sel, t1_wen, t2_sel, t2_wen;
  logic [4:0] t3_rr, t3_rsp;
  logic [6:0] t5_sel, t5_wen, t5_rr;

  initial begin
    rst = 1'b1;
    full_force = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin head[i] = 0; tail[i] = 0; end
    driveInputs();
    repeat (3) applyStimulus();
    rst = 1'b0;
    driveInputs();
    applyStimulus();
    checkOutput("rst_sel", {31'b0, s_sel}, 0);
    checkOutput("rst_busy", {31'b0, s_busy}, 0);
    checkOutput("rst_grant", {30'b0, s_grant}, 0);
    checkOutput("rst_rsp", {28'b0, s_rsp}, 0);
    checkOutput("rst_ack", {28'b0, s_ack}, 0);
    checkOutput("rst_wen", {31'b0, s_wen}, 0);

    // Single requester burst split by MAX_BURST.
    t1_sel = 10'b0111011110;
    t1_wen = 10'b0011011110;
    for (int k = 0; k < 6; k++) begin
      addOp(2, 1'b1, 8'hA0 + 8'(k));
      exp_w.push_back({2'd2, 8'hA0 + 8'(k)});
    end
    driveInputs();
    for (int k = 0; k < 10; k++) begin
      applyStimulus();
      checkOutput($sformatf("t1_sel%0d", k), {31'b0, s_sel}, {31'b0, t1_sel[k]});
      checkOutput($sformatf("t1_wen%0d", k), {31'b0, s_wen}, {31'b0, t1_wen[k]});
      if (t1_sel[k]) checkOutput($sformatf("t1_gid%0d", k), {30'b0, s_grant}, 2);
    end

    // Round-robin order from ptr = 0.
    rst = 1'b1; driveInputs(); applyStimulus(); rst = 1'b0;
    fifo_q.delete();
    driveInputs();
    addOp(0, 1'b1, 8'h10); addOp(1, 1'b1, 8'h11); addOp(3, 1'b1, 8'h13);
    exp_w.push_back({2'd0, 8'h10}); exp_w.push_back({2'd1, 8'h11}); exp_w.push_back({2'd3, 8'h13});
    driveInputs();
    t2_sel = 10'b0110110110;
    t2_wen = 10'b0010010010;
    for (int k = 0; k < 10; k++) begin
      applyStimulus();
      checkOutput($sformatf("t2_sel%0d", k), {31'b0, s_sel}, {31'b0, t2_sel[k]});
      checkOutput($sformatf("t2_wen%0d", k), {31'b0, s_wen}, {31'b0, t2_wen[k]});
    end
    // ptr wrapped back to 0, so requester 0 must win over 1.
    addOp(1, 1'b1, 8'h21); addOp(0, 1'b1, 8'h20);
    exp_w.push_back({2'd0, 8'h20}); exp_w.push_back({2'd1, 8'h21});
    driveInputs();
    repeat (7) applyStimulus();

    // Two reads with registered responses.
    fifo_q.delete();
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
    addOp(1, 1'b0, 8'h00); addOp(1, 1'b0, 8'h00);
    exp_r.push_back({2'd1, 8'h11}); exp_r.push_back({2'd1, 8'h22});
    driveInputs();
    t3_rr  = 5'b00110;
    t3_rsp = 5'b01100;
    for (int k = 0; k < 5; k++) begin
      applyStimulus();
      checkOutput($sformatf("t3_rready%0d", k), {31'b0, s_rready}, {31'b0, t3_rr[k]});
      checkOutput($sformatf("t3_rsp%0d", k), {31'b0, s_rsp[1]}, {31'b0, t3_rsp[k]});
    end

    // Full FIFO stalls the write grant until the requester withdraws.
    full_force = 1'b1;
    fifo_q.delete();
    fifo_q.push_back(8'h44);
    addOp(0, 1'b1, 8'h30); addOp(1, 1'b0, 8'h00);
    exp_r.push_back({2'd1, 8'h44});
    driveInputs();
    applyStimulus();
    checkOutput("t4_idle_sel", {31'b0, s_sel}, 0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus();
      checkOutput($sformatf("t4_hold_sel%0d", k), {31'b0, s_sel}, 1);
      checkOutput($sformatf("t4_hold_wen%0d", k), {31'b0, s_wen}, 0);
      checkOutput($sformatf("t4_hold_gid%0d", k), {30'b0, s_grant}, 0);
    end
    head[0] = tail[0];
    driveInputs();
    applyStimulus();
    checkOutput("t4_drop_sel", {31'b0, s_sel}, 1);
    checkOutput("t4_drop_wen", {31'b0, s_wen}, 0);
    applyStimulus();
    checkOutput("t4_gap_sel", {31'b0, s_sel}, 0);
    applyStimulus();
    checkOutput("t4_rd_gid", {30'b0, s_grant}, 1);
    checkOutput("t4_rd_rready", {31'b0, s_rready}, 1);
    checkOutput("t4_rd_dir", {31'b0, s_is_write}, 0);
    full_force = 1'b0;
    driveInputs();
    repeat (2) applyStimulus();

    // Direction change forces re-arbitration.
    fifo_q.delete();
    fifo_q.push_back(8'h66);
    addOp(3, 1'b1, 8'h5A); addOp(3, 1'b0, 8'h00);
    exp_w.push_back({2'd3, 8'h5A});
    exp_r.push_back({2'd3, 8'h66});
    driveInputs();
    t5_sel = 7'b0110110;
    t5_wen = 7'b0000010;
    t5_rr  = 7'b0010000;
    for (int k = 0; k < 7; k++) begin
      applyStimulus();
      checkOutput($sformatf("t5_sel%0d", k), {31'b0, s_sel}, {31'b0, t5_sel[k]});
      checkOutput($sformatf("t5_wen%0d", k), {31'b0, s_wen}, {31'b0, t5_wen[k]});
      checkOutput($sformatf("t5_rready%0d", k), {31'b0, s_rready}, {31'b0, t5_rr[k]});
      if (k == 4) checkOutput("t5_dir", {31'b0, s_is_write}, 0);
    end

    // Reset during the second fire of a burst.
    fifo_q.delete();
    addOp(3, 1'b1, 8'hB0); addOp(3, 1'b1, 8'hB1); addOp(3, 1'b1, 8'hB2);
    exp_w.push_back({2'd3, 8'hB0}); exp_w.push_back({2'd3, 8'hB1});
    driveInputs();
    applyStimulus();
    checkOutput("t6_idle_sel", {31'b0, s_sel}, 0);
    applyStimulus();
    checkOutput("t6_fire1", {31'b0, s_wen}, 1);
    rst = 1'b1;
    addOp(2, 1'b1, 8'hC2);
    driveInputs();
    applyStimulus();
    checkOutput("t6_fire2", {31'b0, s_wen}, 1);
    rst = 1'b0;
    exp_w.push_back({2'd2, 8'hC2}); exp_w.push_back({2'd3, 8'hB2});
    driveInputs();
    applyStimulus();
    checkOutput("t6_rst_sel", {31'b0, s_sel}, 0);
    checkOutput("t6_rst_wen", {31'b0, s_wen}, 0);
    checkOutput("t6_rst_ack", {28'b0, s_ack}, 0);
    checkOutput("t6_rst_busy", {31'b0, s_busy}, 0);
    checkOutput("t6_rst_gid", {30'b0, s_grant}, 0);
    checkOutput("t6_rst_rsp", {28'b0, s_rsp}, 0);
    applyStimulus();
    checkOutput("t6_regrant_gid", {30'b0, s_grant}, 2);
    checkOutput("t6_regrant_wen", {31'b0, s_wen}, 1);
    repeat (8) applyStimulus();

    checkOutput("exp_w_drained", exp_w.size(), 0);
    checkOutput("exp_r_drained", exp_r.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_port_arb.md
# fifo_port_arb

Round-robin arbiter that shares the single FIFO data port (`sel`/`is_write`/`w_*`/`r_*`) of `fifo_top` between `NUM_REQ` independent requesters. It sits between the requester clients and `fifo_top`, and sequences each grant as a burst of same-direction operations. It inserts one idle cycle between grants so that `sel`/`is_write` never change while an operation is in flight. The register bus of `fifo_top` is outside this block.

## Interface
- `NUM_REQ`, 4, number of requesters (1..8)
- `WIDTH`, 8, FIFO data width
- `MAX_BURST`, 4, maximum operations per grant (1..16)
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_REQ  requester i has an operation pending
- `req_write`  in  NUM_REQ  operation type: 1 = write, 0 = read
- `req_wdata`  in  NUM_REQ*WIDTH  write data; requester i occupies slice [i*WIDTH +: WIDTH]
- `req_ack`  out  NUM_REQ  one-cycle pulse in the cycle requester i's operation executes
- `rsp_valid`  out  NUM_REQ  one-cycle pulse; read data for requester i is on `rsp_data`
- `rsp_data`  out  WIDTH  registered read data
- `grant_id`  out  $clog2(NUM_REQ) (min 1)  index of the current grantee
- `busy`  out  1  a grant is active (state SERVE)
- `sel`  out  1  FIFO port select
- `is_write`  out  1  FIFO port direction
- `w_enable`  out  1  FIFO write strobe
- `w_data`  out  WIDTH  FIFO write data
- `w_ready`  in  1  FIFO can accept a write
- `r_enable`  in  1  FIFO has data; `r_data` is valid (first-word fall-through)
- `r_ready`  out  1  FIFO pop strobe
- `r_data`  in  WIDTH  FIFO read data

## Operation
- **States.** The FSM has two states, IDLE and SERVE. Reset puts the FSM in IDLE, sets `ptr` to 0, and clears `burst_cnt`, `grant_id`, `rsp_data` and `rsp_valid`.
- **IDLE.**
  - `sel` = 0 and all strobes are 0.
  - If any `req_valid` is set, pick the first set bit searching upward from `ptr`, wrapping modulo NUM_REQ.
  - Register the winner in `grant_id`, latch `dir` = `req_write[winner]`, clear `burst_cnt`, then go to SERVE.
- **SERVE outputs.** `sel` = 1 and `is_write` = `dir`. `w_data` = the slice of `req_wdata` for `grant_id`. `busy` = 1.
- **fire.** The current operation executes (fires) when all of the following hold:
  - `req_valid[g]` is set;
  - `req_write[g]` equals `dir`;
  - the FIFO can serve it: `w_ready` for a write, `r_enable` for a read.
- **Strobes and responses.**
  - `w_enable` = fire & `dir`; `r_ready` = fire & !`dir`; `req_ack[g]` = fire. All three are combinational.
  - On a read fire, `r_data` is registered into `rsp_data` and `rsp_valid[g]` pulses in the next cycle.
- **Burst counting.** Each fire increments `burst_cnt`.
- **Leaving SERVE.** Go to IDLE after the cycle in which any of these holds:
  - the fire that makes `burst_cnt` equal `MAX_BURST`;
  - `req_valid[g]` = 0;
  - `req_write[g]` differs from `dir` (a direction change always forces a re-arbitration).
- **Pointer update.** On exit from SERVE, `ptr` = (g+1) mod NUM_REQ.
- **FIFO not ready.**
  - A full FIFO on a write grant, or an empty FIFO on a read grant, holds SERVE with no fire and no timeout.
  - The requester may withdraw `req_valid`, which releases the grant.
- **Requester contract.**
  - `req_valid`, `req_write` and `req_wdata` stay stable until `req_ack`.
  - The next operation may be presented in the cycle after `req_ack`; it then fires no earlier than that cycle.
- **Unused index bits.** When NUM_REQ is not a power of 2, the unused `ptr`/`grant_id` encodings are never produced.

## Timing
- **Arbitration latency.** With the arbiter in IDLE, a `req_valid` first set in cycle N is granted in cycle N+1 (SERVE). The first fire can occur in N+1.
- **Throughput.** One operation per cycle within a burst. A grant switch costs exactly 1 idle cycle (`sel` = 0).
- **Read response.** `rsp_valid`/`rsp_data` appear 1 cycle after the fire.
- **Reset.**
  - `rst` asserted in any cycle, including mid-burst, drives every output to 0 in the following cycle and returns the FSM to IDLE with `ptr` = 0.
  - An operation that has not been acked is not executed. A pending `rsp_valid` is dropped.
- **Simultaneous events.**
  - A fire in the same cycle as a `req_valid` drop by another requester has no effect on the current grant.
  - When the last burst fire coincides with a new request from the same requester, the requester re-arbitrates in IDLE behind any others.

## Configuration
- `FIFO_ARB_PRIO_EN` defined:
  - requester 0 has strict priority at every IDLE arbitration;
  - its grants are unlimited by `MAX_BURST`;
  - `ptr` round-robin applies only among requesters 1..NUM_REQ-1.
- Undefined: pure round-robin as described above.

## Test plan
- **Single requester writes.** Requester 2 writes 0xA0..0xA5 (6 ops), FIFO empty, `MAX_BURST` = 4.
  - `sel` rises 1 cycle after `req_valid`.
  - 4 consecutive `w_enable` with data 0xA0..0xA3, then 1 idle cycle, then 2 more with 0xA4..0xA5.
  - `grant_id` = 2 throughout.
- **Round-robin order.** Requesters 0, 1 and 3 each request 1 write simultaneously from `ptr` = 0.
  - Grants go 0, 1, 3, each separated by 1 idle cycle.
  - Afterwards `ptr` = 0.
- **Read response.** FIFO holds 0x11, 0x22; requester 1 issues 2 reads.
  - `r_ready` is high for 2 cycles.
  - `rsp_valid[1]` pulses 1 cycle after each, with `rsp_data` = 0x11 then 0x22.
- **Full stall and release.** FIFO full (`w_ready` = 0) while requester 0 writes.
  - SERVE is held with no `w_enable` for 10 cycles.
  - Requester 0 drops `req_valid`, then requester 1's pending read is granted after 1 idle cycle.
- **Direction change.** Requester 3 writes 0x5A, then immediately presents a read.
  - The write fires, SERVE exits, `sel` = 0 for 1 cycle.
  - A new grant follows with `is_write` = 0.
- **Reset mid-burst.** `rst` asserted during the 2nd fire of a burst.
  - Next cycle: `sel` = `w_enable` = `req_ack` = `busy` = 0, `grant_id` = 0.
  - The first grant after release goes to the lowest active requester.
